// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// No build macros are used in this file.
package mul_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int MUL_W = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection for the shared multiplier.
// Build macro MUL_SHARE_RR_EN: round-robin from ptr_i; otherwise lowest index wins.
module rr_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

`ifndef MUL_SHARE_RR_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;
`endif

    always_comb begin
        logic [ID_W-1:0] cand;
        cand  = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MUL_SHARE_RR_EN
            cand = ID_W'((int'(ptr_i) + k) % NUM_REQ);
`else
            cand = ID_W'(k);
`endif
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one external 8x8 low-byte multiplier among NUM_REQ requesters.
// Build macro MUL_SHARE_RR_EN selects round-robin arbitration (default: fixed priority).
//
// state  | meaning
// IDLE   | waiting for a request; grant is offered combinationally
// SETTLE | operands registered on mul_a/mul_b, waiting for the multiplier
// DONE   | product held on rsp_* until rsp_ready
module mul_share_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WAIT_CYC = 1,
    parameter int ID_W     = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*MUL_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_W-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [MUL_W-1:0]         rsp_data,
    output logic [ID_W-1:0]          rsp_id,
    output logic [MUL_W-1:0]         mul_a,
    output logic [MUL_W-1:0]         mul_b,
    input  logic [MUL_W-1:0]         mul_out,
    output logic                     busy
);

    localparam int CNT_W = id_width(WAIT_CYC);

    if (WAIT_CYC < 1) begin : g_bad_wait
        $error("mul_share_ctrl: WAIT_CYC must be at least 1");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
        $error("mul_share_ctrl: NUM_REQ must be in 2..8");
    end

    state_e             state_q;
    logic [MUL_W-1:0]   opa_q;
    logic [MUL_W-1:0]   opb_q;
    logic [MUL_W-1:0]   rsp_data_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [ID_W-1:0]    arb_ptr;
    logic [MUL_W-1:0]   a_lane [NUM_REQ];
    logic [MUL_W-1:0]   b_lane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign a_lane[i] = req_a[MUL_W*i +: MUL_W];
        assign b_lane[i] = req_b[MUL_W*i +: MUL_W];
    end

`ifdef MUL_SHARE_RR_EN
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    assign ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = '0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (arb_ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    // Grant is only offered in IDLE, and never while reset is asserted.
    assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
    assign cnt_d     = cnt_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef MUL_SHARE_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        opa_q    <= a_lane[gnt_idx];
                        opb_q    <= b_lane[gnt_idx];
                        rsp_id_q <= gnt_idx;
                        cnt_q    <= CNT_W'(WAIT_CYC - 1);
                        state_q  <= SETTLE;
`ifdef MUL_SHARE_RR_EN
                        ptr_q    <= ptr_d;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        rsp_data_q  <= mul_out;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_a     = opa_q;
    assign mul_b     = opb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: one instance with WAIT_CYC=1, one with WAIT_CYC=3.
// Arbitration expectations follow MUL_SHARE_RR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_mul_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, busy;
    logic [7:0]  rsp_data, mul_a, mul_b, mul_out;
    logic [1:0]  rsp_id;

    logic [3:0]  req_valid3, req_ready3;
    logic [31:0] req_a3, req_b3;
    logic        rsp_valid3, rsp_ready3, busy3;
    logic [7:0]  rsp_data3, mul_a3, mul_b3, mul_out3;
    logic [1:0]  rsp_id3;

    // External multiplier beside the controller: low byte of the product.
    assign mul_out  = mul_a * mul_b;
    assign mul_out3 = mul_a3 * mul_b3;

    mul_share_ctrl #(.NUM_REQ(4), .WAIT_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .busy(busy)
    );

    mul_share_ctrl #(.NUM_REQ(4), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_id(rsp_id3),
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_out(mul_out3),
        .busy(busy3)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF; req_a = 32'h0102_0304; req_b = 32'h0506_0708; rsp_ready = 1'b1;
        req_valid3 = 4'h0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin errors++; $display("FAIL reset_mul_ab got=%0d/%0d exp=0/0", mul_a, mul_b); end
        checks++; if (rsp_data !== 8'd0 || rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp got=%0d/%0d exp=0/0", rsp_data, rsp_id); end
        checks++; if (busy3 !== 1'b0 || rsp_valid3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got=%b/%b exp=0/0", busy3, rsp_valid3); end
        req_valid = 4'h0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        req_valid = 4'b0001; req_a = 32'd12; req_b = 32'd10; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0000; req_a = 32'd99; req_b = 32'd99;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_t1 got valid=%b busy=%b exp valid=0 busy=1", rsp_valid, busy); end
        checks++; if (mul_a !== 8'd12 || mul_b !== 8'd10) begin errors++; $display("FAIL basic_mul_ab got=%0d/%0d exp=12/10", mul_a, mul_b); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_data !== 8'd120) begin errors++; $display("FAIL basic_data got=%0d exp=120", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_id got=%0d exp=0", rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b valid=%b exp 0/0", busy, rsp_valid); end
    endtask

    task automatic test_truncation();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic [7:0] te [3];
        logic [1:0] ti [3];
        ta = '{8'd255, 8'd16, 8'd0};
        tb = '{8'd255, 8'd16, 8'd200};
        te = '{8'h01, 8'h00, 8'h00};
        ti = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req_a = {4{ta[i]}}; req_b = {4{tb[i]}};
            req_valid = 4'b0001 << ti[i];
            @(posedge clk); #1;
            req_valid = 4'b0000;
            @(negedge clk);
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== te[i]) begin errors++; $display("FAIL trunc_%0d got valid=%b data=%h exp valid=1 data=%h", i, rsp_valid, rsp_data, te[i]); end
            checks++; if (rsp_id !== ti[i]) begin errors++; $display("FAIL trunc_id_%0d got=%0d exp=%0d", i, rsp_id, ti[i]); end
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL trunc_idle_%0d got busy=%b exp=0", i, busy); end
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_gnt [5];
        int w;
`ifdef MUL_SHARE_RR_EN
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        req_a = {8'd4, 8'd3, 8'd2, 8'd1}; req_b = {4{8'd10}};
        req_valid = 4'hF; rsp_ready = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            w = 0;
            while ((busy !== 1'b0 || req_ready === 4'b0000) && w < 10) begin
                @(negedge clk);
                w++;
            end
            checks++; if (req_ready !== exp_gnt[n]) begin errors++; $display("FAIL arb_order_%0d got=%b exp=%b waited=%0d", n, req_ready, exp_gnt[n], w); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 4'h0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_drain got busy=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        req_a = {8'd5, 8'd0, 8'd4, 8'd0}; req_b = {8'd6, 8'd0, 8'd4, 8'd0};
        req_valid = 4'b1000; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd30 || rsp_id !== 2'd3) begin errors++; $display("FAIL stall_hold_%0d got valid=%b data=%0d id=%0d exp 1/30/3", i, rsp_valid, rsp_data, rsp_id); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready_%0d got=%b exp=0000", i, req_ready); end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL stall_hs got valid=%b ready=%b exp 1/0000", rsp_valid, req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010 || busy !== 1'b0) begin errors++; $display("FAIL stall_resume got ready=%b busy=%b exp 0010/0", req_ready, busy); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'd16 || rsp_id !== 2'd1) begin errors++; $display("FAIL stall_next got valid=%b data=%0d id=%0d exp 1/16/1", rsp_valid, rsp_data, rsp_id); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(posedge clk); #1;
        req_a = 32'd3; req_b = 32'd3; req_valid = 4'b0001; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_settle got busy=%b exp=1", busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
        checks++; if (mul_a !== 8'd0) begin errors++; $display("FAIL rstmid_mul_a got=%0d exp=0", mul_a); end
        @(negedge clk); #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got activity=%b exp=0", seen); end
    endtask

    task automatic test_wait3();
        @(posedge clk); #1;
        req_a3 = {8'd0, 8'd7, 8'd0, 8'd0}; req_b3 = {8'd0, 8'd9, 8'd0, 8'd0};
        req_valid3 = 4'b0100; rsp_ready3 = 1'b1;
        @(negedge clk);
        checks++; if (req_ready3 !== 4'b0100) begin errors++; $display("FAIL w3_grant got=%b exp=0100", req_ready3); end
        @(posedge clk); #1;
        req_valid3 = 4'b0000; req_a3 = '1; req_b3 = '1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b1) begin errors++; $display("FAIL w3_settle_%0d got valid=%b busy=%b exp 0/1", i, rsp_valid3, busy3); end
            checks++; if (mul_a3 !== 8'd7 || mul_b3 !== 8'd9) begin errors++; $display("FAIL w3_mul_ab_%0d got=%0d/%0d exp=7/9", i, mul_a3, mul_b3); end
        end
        @(negedge clk);
        checks++; if (rsp_valid3 !== 1'b1 || rsp_data3 !== 8'd63 || rsp_id3 !== 2'd2) begin errors++; $display("FAIL w3_rsp got valid=%b data=%0d id=%0d exp 1/63/2", rsp_valid3, rsp_data3, rsp_id3); end
        @(negedge clk);
        checks++; if (busy3 !== 1'b0 || mul_a3 !== 8'd7 || mul_b3 !== 8'd9) begin errors++; $display("FAIL w3_idle got busy=%b mul=%0d/%0d exp 0 7/9", busy3, mul_a3, mul_b3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_arbitration();
        test_stall();
        test_reset_mid();
        test_wait3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
